// File: rtl/pipe_hazard_scoreboard_pkg.sv
// Shared pipeline types: in-flight slot record and operand-forward select encodings.
// Combinational helpers only; no state, no latency, no backpressure.
package pipe_hazard_scoreboard_pkg;

  // Slot dest is stored at a fixed width so one record type serves every REG_AW <= DEST_W.
  localparam int DEST_W = 8;

  typedef struct packed {
    logic              valid;
    logic [DEST_W-1:0] dest;
    logic              is_load;
  } slot_t;

  typedef logic [2:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF = 3'd0;

  function automatic fwd_sel_t slot_to_fwd(input logic [2:0] idx);
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/hazard_slot_match.sv
// Compares one source register against every in-flight slot; reports any hit,
// the youngest hitting slot and whether slot 0 hits as a load. Purely combinational.
module hazard_slot_match
  import pipe_hazard_scoreboard_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int REG_AW = 4
) (
  input  slot_t [STAGES-1:0] slots,
  input  logic [REG_AW-1:0]  src,
  input  logic               src_en,
  output logic               any_match,
  output logic [2:0]         youngest_idx,
  output logic               load_match
);

  logic [STAGES-1:0] hit;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      hit[k] = src_en & slots[k].valid & (slots[k].dest == DEST_W'(src));
    end
  end

  // Walk oldest to youngest so the lowest index is the one left standing.
  always_comb begin
    any_match    = 1'b0;
    youngest_idx = 3'd0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (hit[k]) begin
        any_match    = 1'b1;
        youngest_idx = 3'(k);
      end
    end
    load_match = hit[0] & slots[0].is_load;
  end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks STAGES in-flight writers, raises hazard and forward selects.
// Zero-cycle hazard/fwd_sel; mem_wait freezes slots and stall_cnt. Macro HAZARD_FWD_EN enables forwarding.
module pipe_hazard_scoreboard
  import pipe_hazard_scoreboard_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_wb_en,
  input  logic              id_mem_r_en,
  input  logic [REG_AW-1:0] id_dest,
  input  logic [REG_AW-1:0] src1,
  input  logic [REG_AW-1:0] src2,
  input  logic              two_src,
  input  logic              flush,
  input  logic              mem_wait,
  input  logic              cnt_clr,
  output logic              hazard,
  output logic [2:0]        fwd_sel1,
  output logic [2:0]        fwd_sel2,
  output logic [CNT_W-1:0]  stall_cnt
);

  slot_t [STAGES-1:0] slot_q;
  slot_t              slot_new;

  logic       any1, any2;
  logic       ld1, ld2;
  logic [2:0] idx1, idx2;

  hazard_slot_match #(.STAGES(STAGES), .REG_AW(REG_AW)) u_match1 (
    .slots        (slot_q),
    .src          (src1),
    .src_en       (1'b1),
    .any_match    (any1),
    .youngest_idx (idx1),
    .load_match   (ld1)
  );

  hazard_slot_match #(.STAGES(STAGES), .REG_AW(REG_AW)) u_match2 (
    .slots        (slot_q),
    .src          (src2),
    .src_en       (two_src),
    .any_match    (any2),
    .youngest_idx (idx2),
    .load_match   (ld2)
  );

`ifdef HAZARD_FWD_EN
  // Only a load still in EXE cannot be bypassed; everything else forwards.
  always_comb begin
    hazard   = id_valid & ~flush & (ld1 | ld2);
    fwd_sel1 = (hazard || !any1) ? FWD_RF : slot_to_fwd(idx1);
    fwd_sel2 = (hazard || !any2) ? FWD_RF : slot_to_fwd(idx2);
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{idx1, idx2, ld1, ld2};

  always_comb begin
    hazard   = id_valid & ~flush & (any1 | any2);
    fwd_sel1 = FWD_RF;
    fwd_sel2 = FWD_RF;
  end
`endif

  // A stalled or flushed ID instruction enters EXE as a bubble.
  always_comb begin
    slot_new         = '0;
    slot_new.valid   = id_valid & id_wb_en & ~hazard & ~flush;
    slot_new.dest    = DEST_W'(id_dest);
    slot_new.is_load = id_mem_r_en;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q    <= '0;
      stall_cnt <= '0;
    end else begin
      if (!mem_wait) begin
        for (int k = 1; k < STAGES; k++) begin
          slot_q[k] <= slot_q[k-1];
        end
        slot_q[0] <= slot_new;
      end
      if (cnt_clr) begin
        stall_cnt <= '0;
      end else if (hazard && !mem_wait && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Bench for pipe_hazard_scoreboard: directed producer/consumer sequences checked against
// a slot-list model every cycle, plus hand-computed expectations at key points.
module tb_pipe_hazard_scoreboard;

  localparam int STAGES  = 2;
  localparam int REG_AW  = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              id_valid = 1'b0, id_wb_en = 1'b0, id_mem_r_en = 1'b0;
  logic [REG_AW-1:0] id_dest = '0, src1 = '0, src2 = '0;
  logic              two_src = 1'b0, flush = 1'b0, mem_wait = 1'b0, cnt_clr = 1'b0;
  logic              hazard;
  logic [2:0]        fwd_sel1, fwd_sel2;
  logic [CNT_W-1:0]  stall_cnt;

  always #5 clk = ~clk;

  pipe_hazard_scoreboard #(.STAGES(STAGES), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_wb_en    (id_wb_en),
    .id_mem_r_en (id_mem_r_en),
    .id_dest     (id_dest),
    .src1        (src1),
    .src2        (src2),
    .two_src     (two_src),
    .flush       (flush),
    .mem_wait    (mem_wait),
    .cnt_clr     (cnt_clr),
    .hazard      (hazard),
    .fwd_sel1    (fwd_sel1),
    .fwd_sel2    (fwd_sel2),
    .stall_cnt   (stall_cnt)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: list of in-flight writers, index 0 youngest.
  bit m_valid[STAGES];
  int m_dest[STAGES];
  bit m_load[STAGES];
  int m_cnt;

  function automatic void model_out(output bit hz, output int f1, output int f2);
    int y1 = -1;
    int y2 = -1;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (m_valid[k] && m_dest[k] == int'(src1)) y1 = k;
      if (two_src && m_valid[k] && m_dest[k] == int'(src2)) y2 = k;
    end
    if (FWD) begin
      hz = id_valid && !flush && m_load[0] && (y1 == 0 || y2 == 0);
      f1 = hz ? 0 : y1 + 1;
      f2 = hz ? 0 : y2 + 1;
    end else begin
      hz = id_valid && !flush && (y1 >= 0 || y2 >= 0);
      f1 = 0;
      f2 = 0;
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    bit hz;
    int f1, f2;
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) begin
        m_valid[k] = 1'b0;
        m_dest[k]  = 0;
        m_load[k]  = 1'b0;
      end
      m_cnt = 0;
    end else begin
      model_out(hz, f1, f2);
      if (!mem_wait) begin
        for (int k = STAGES - 1; k > 0; k--) begin
          m_valid[k] = m_valid[k-1];
          m_dest[k]  = m_dest[k-1];
          m_load[k]  = m_load[k-1];
        end
        m_valid[0] = id_valid && id_wb_en && !hz && !flush;
        m_dest[0]  = int'(id_dest);
        m_load[0]  = id_mem_r_en;
        if (hz && m_cnt < CNT_MAX) m_cnt++;
      end
      if (cnt_clr) m_cnt = 0;
    end
  end

  always @(negedge clk) begin
    bit hz;
    int f1, f2;
    if (cmp_en) begin
      model_out(hz, f1, f2);
      chk("cyc_hazard", int'(hazard), int'(hz));
      chk("cyc_fwd_sel1", int'(fwd_sel1), f1);
      chk("cyc_fwd_sel2", int'(fwd_sel2), f2);
      chk("cyc_stall_cnt", int'(stall_cnt), m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit wb, input bit ld, input int d,
                       input int s1, input int s2, input bit two);
    id_valid    = v;
    id_wb_en    = wb;
    id_mem_r_en = ld;
    id_dest     = REG_AW'(d);
    src1        = REG_AW'(s1);
    src2        = REG_AW'(s2);
    two_src     = two;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2 rst = 1'b0;
    #10;
    chk("rst_hazard", int'(hazard), 0);
    chk("rst_fwd_sel1", int'(fwd_sel1), 0);
    chk("rst_fwd_sel2", int'(fwd_sel2), 0);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    cmp_en = 1'b1;
    tick();
    rst = 1'b1;

    // Non-load r3 writer followed by an r3 reader.
    tick(); drive(1, 1, 0, 3, 1, 2, 0); #1 chk("r3_prod_hazard", int'(hazard), 0);
    tick(); drive(1, 0, 0, 0, 3, 0, 0); #1;
    chk("r3_use_hazard_c1", int'(hazard), FWD ? 0 : 1);
    chk("r3_use_fwd_sel1", int'(fwd_sel1), FWD ? 1 : 0);
    tick(); #1 chk("r3_use_hazard_c2", int'(hazard), FWD ? 0 : 1);
    tick(); #1 chk("r3_use_hazard_c3", int'(hazard), 0);
    tick(); idle();
    tick(); tick();

    // Load r5, then r5 as a live second operand.
    drive(1, 1, 1, 5, 1, 2, 0);
    tick(); drive(1, 0, 0, 0, 1, 5, 1); #1 chk("lu_r5_hazard_c1", int'(hazard), 1);
    tick(); #1;
    chk("lu_r5_hazard_c2", int'(hazard), FWD ? 0 : 1);
    chk("lu_r5_fwd_sel2", int'(fwd_sel2), FWD ? 2 : 0);
    tick(); idle();
    tick(); tick();

    // Same load, but src2 is not a live operand.
    drive(1, 1, 1, 5, 1, 2, 0);
    tick(); drive(1, 0, 0, 0, 1, 5, 0); #1;
    chk("lu_r5_one_src_hazard", int'(hazard), 0);
    chk("lu_r5_one_src_fwd_sel2", int'(fwd_sel2), 0);
    tick(); idle();
    tick(); tick();

    // r4 written twice back to back; reader must take the youngest.
    drive(1, 1, 0, 4, 1, 2, 0);
    tick(); drive(1, 1, 0, 4, 1, 2, 0);
    tick(); drive(1, 0, 0, 0, 4, 0, 0); #1;
    chk("r4_youngest_hazard", int'(hazard), FWD ? 0 : 1);
    chk("r4_youngest_fwd_sel1", int'(fwd_sel1), FWD ? 1 : 0);
    tick(); idle();
    tick(); tick(); tick();
    cnt_clr = 1'b1;
    tick(); cnt_clr = 1'b0; #1 chk("cnt_clr_idle", int'(stall_cnt), 0);

    // Load-use stall frozen by mem_wait for three cycles.
    drive(1, 1, 1, 6, 1, 2, 0);
    tick(); drive(1, 0, 0, 0, 6, 0, 0); mem_wait = 1'b1; #1;
    chk("mw_hazard_c1", int'(hazard), 1);
    chk("mw_cnt_c1", int'(stall_cnt), 0);
    tick(); #1;
    chk("mw_hazard_c2", int'(hazard), 1);
    chk("mw_cnt_c2", int'(stall_cnt), 0);
    tick(); #1;
    chk("mw_hazard_c3", int'(hazard), 1);
    chk("mw_cnt_c3", int'(stall_cnt), 0);
    tick(); mem_wait = 1'b0; #1;
    chk("mw_thaw_hazard", int'(hazard), 1);
    chk("mw_thaw_cnt", int'(stall_cnt), 0);
    tick(); #1 chk("mw_cnt_after", int'(stall_cnt), 1);
    idle();
    tick(); tick(); tick();

    // Flush coincident with a matching source; the flushed writer must become a bubble.
    drive(1, 1, 0, 7, 1, 2, 0);
    tick(); drive(1, 1, 0, 9, 7, 0, 0); flush = 1'b1; #1;
    chk("flush_hazard", int'(hazard), 0);
    tick(); drive(1, 0, 0, 0, 9, 0, 0); flush = 1'b0; #1;
    chk("flush_bubble_hazard", int'(hazard), 0);
    chk("flush_bubble_fwd_sel1", int'(fwd_sel1), 0);
    tick(); idle();
    tick(); tick();

    // Drive at least 20 stall cycles into a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 1, 8, 1, 2, 0);
      tick(); drive(1, 0, 0, 0, 8, 0, 0);
      tick(); tick(); tick();
    end
    idle(); #1 chk("cnt_saturated", int'(stall_cnt), CNT_MAX);

    // Asynchronous reset in the middle of a stall.
    tick(); drive(1, 1, 1, 8, 1, 2, 0);
    tick(); drive(1, 0, 0, 0, 8, 0, 0); #1 chk("arst_pre_hazard", int'(hazard), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_hazard", int'(hazard), 0);
    chk("arst_fwd_sel1", int'(fwd_sel1), 0);
    chk("arst_stall_cnt", int'(stall_cnt), 0);
    tick(); rst = 1'b1; #1 chk("arst_post_hazard", int'(hazard), 0);

    // Clear wins over an increment on the same edge.
    tick(); drive(1, 1, 1, 8, 1, 2, 0);
    tick(); drive(1, 0, 0, 0, 8, 0, 0); cnt_clr = 1'b1; #1 chk("clr_prio_hazard", int'(hazard), 1);
    tick(); cnt_clr = 1'b0; #1 chk("clr_prio_cnt", int'(stall_cnt), 0);
    tick(); idle();
    tick(); tick();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
